// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the arbitrated register bank.
package reg_bank_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Never returns 0 so that derived vector widths stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Rotating first-one search: the winner is the first requester at or after start, wrapping.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  exclude,
  output logic          valid,
  output logic [IW-1:0] winner
);

  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!valid && req[idx] && !exclude[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by N_REQ requesters through a round-robin arbiter with bounded bursts.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int LOCK_MAX = 8,
  localparam int AW      = clog2(DEPTH),
  localparam int OW      = clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  logic [N_REQ-1:0]      op_clr,
  input  logic [N_REQ*AW-1:0]   addr,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                  clr_all,
  output logic [N_REQ-1:0]      gnt,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int CW = clog2(LOCK_MAX + 1);

  state_t           state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [OW-1:0]    owner_n;
  logic [OW-1:0]    rr_ptr, rr_ptr_n;
  logic [CW-1:0]    lock_cnt, lock_cnt_n;

  logic [WIDTH-1:0] bank [DEPTH];

  logic             owner_req;
  logic             owner_lock;
  logic [N_REQ-1:0] owner_mask;
  logic [OW-1:0]    next_ptr;
  logic             hold;

  logic             commit;
  logic [AW-1:0]    c_addr;
  logic             c_op;
  logic [WIDTH-1:0] c_data;

  logic [OW-1:0]    pick_start;
  logic [N_REQ-1:0] pick_exclude;
  logic             pick_valid;
  logic [OW-1:0]    pick_winner;

  always_comb begin
    owner_req  = req[owner];
    owner_lock = lock[owner];
    owner_mask = N_REQ'(1) << owner;
    next_ptr   = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
    hold       = (state == GRANT) && owner_lock && owner_req && (lock_cnt < CW'(LOCK_MAX));
    commit     = (state == GRANT) && owner_req;
    c_addr     = addr[int'(owner)*AW +: AW];
    c_op       = op_clr[owner];
    c_data     = wdata[int'(owner)*WIDTH +: WIDTH];
  end

  // A releasing owner only competes again when nobody else is asking.
  always_comb begin
    pick_start   = rr_ptr;
    pick_exclude = '0;
    if (state == GRANT) begin
      pick_start   = next_ptr;
      pick_exclude = (req == owner_mask) ? '0 : owner_mask;
    end
  end

  rr_priority_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_pick (
    .req     (req),
    .start   (pick_start),
    .exclude (pick_exclude),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    lock_cnt_n = lock_cnt;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (pick_valid) begin
          state_n    = GRANT;
          gnt_n      = N_REQ'(1) << pick_winner;
          owner_n    = pick_winner;
          lock_cnt_n = CW'(1);
        end
      end
      GRANT: begin
        if (hold) begin
          lock_cnt_n = lock_cnt + CW'(1);
        end else begin
          rr_ptr_n = next_ptr;
          if (pick_valid) begin
            gnt_n      = N_REQ'(1) << pick_winner;
            owner_n    = pick_winner;
            lock_cnt_n = CW'(1);
          end else begin
            state_n    = IDLE;
            gnt_n      = '0;
            lock_cnt_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      busy     <= |gnt_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  // clr_all wins over the owner's commit; addresses beyond DEPTH match no word.
  always_ff @(posedge clk) begin
    for (int w = 0; w < DEPTH; w++) begin
      if (!n_reset || clr_all) begin
        bank[w] <= '0;
      end else if (commit && (c_addr == AW'(w))) begin
        bank[w] <= (c_op == OP_CLEAR) ? '0 : c_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (rd_addr == AW'(w)) begin
        rd_data = bank[w];
      end
    end
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of DEPTH enable/clear registers between N_REQ requesters.
- Each requester can write or clear one word per granted cycle.
- A round-robin arbiter with bounded lock (burst) support decides ownership.
- Sits between the control agents and the register storage; a single combinational read port serves observers.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, bits per register word
- DEPTH, 4, number of words (≥2); AW = clog2(DEPTH) is derived, not overridable
- LOCK_MAX, 8, maximum consecutive grant cycles for one owner before forced release (≥1)

Ports:
- clk  in  1  rising-edge clock
- n_reset  in  1  synchronous active-low reset
- req  in  N_REQ  per-requester request; held until granted
- lock  in  N_REQ  per-requester burst hold request
- op_clr  in  N_REQ  1 = clear addressed word, 0 = write wdata
- addr  in  N_REQ*AW  word address, requester i in slice [i*AW +: AW]
- wdata  in  N_REQ*WIDTH  write data, requester i in slice [i*WIDTH +: WIDTH]
- clr_all  in  1  synchronous clear of every word
- gnt  out  N_REQ  registered one-hot grant
- busy  out  1  registered; 1 whenever any gnt bit is 1
- owner  out  clog2(N_REQ)  registered index of current/last grantee
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  combinational read of bank[rd_addr]

Behaviour:
- Reset (n_reset=0 at a clk edge):
  - all words 0; gnt 0; busy 0; owner 0
  - round-robin pointer rr_ptr 0; lock counter 0; FSM IDLE
  - reset overrides clr_all and any grant in flight.
- FSM IDLE:
  - if any req bit is 1, pick the first requester at index ≥ rr_ptr, searching upward and wrapping modulo N_REQ.
  - next edge: gnt[pick]=1, owner=pick, lock_cnt=1, go to GRANT.
  - if no req bit is 1, stay in IDLE with gnt=0.
- Request-to-grant latency is exactly 1 cycle from IDLE.
- FSM GRANT (gnt[owner]=1 this cycle):
  - commit at the end of the cycle, only if req[owner]=1: bank[addr_owner] <= op_clr_owner ? 0 : wdata_owner.
  - if req[owner]=0 the grant is wasted and the bank is unchanged.
  - hold: if lock[owner]=1, req[owner]=1 and lock_cnt<LOCK_MAX, stay in GRANT with the same owner and increment lock_cnt.
  - release otherwise: rr_ptr <= (owner+1) mod N_REQ, then re-arbitrate in the same cycle using that new pointer over current req, excluding the releasing owner unless it is the sole requester.
    - on a winner: back-to-back GRANT to the winner next edge, lock_cnt=1.
    - with no other requester: go to IDLE.
  - forced release at LOCK_MAX: a sole requester is regranted immediately with lock_cnt reset to 1.
- Back-to-back grants to different requesters have no idle bubble.
- gnt is always one-hot or zero; busy = |gnt; owner holds its last value while IDLE.
- clr_all=1:
  - all words become 0 at the edge.
  - it takes priority over a same-cycle commit; that commit is discarded.
  - arbitration, gnt and lock_cnt proceed unaffected.
- Writes become visible on rd_data the cycle after commit; there is no bypass.
- Out-of-range addr (DEPTH not a power of 2): no write; rd_data returns 0.
- Requester inputs are sampled only in the commit cycle; a requester must hold its op fields valid while its gnt=1.

Decomposition:
- Package reg_bank_arbiter_pkg:
  - FSM state enum IDLE/GRANT
  - op encoding constants OP_WRITE=0, OP_CLEAR=1
  - clog2 helper function
- Sub-module rr_priority_pick: combinational.
  - inputs: req vector, start pointer, exclude mask
  - outputs: valid and winner index
  - used for both IDLE arbitration and release re-arbitration.
- Storage stays inline as per-word enable/clear registers; no separate module.

Test Plan:
- Reset/idle: n_reset=0 for 2 cycles with all inputs driven → gnt=0, busy=0, owner=0, rd_data=0 at every rd_addr.
- Single write: req[2]=1, addr=1, wdata=0xA5, op_clr=0 → gnt=4'b0100 next cycle. Following cycle rd_addr=1 gives 0xA5; then clear op to addr 1 → reads 0x00.
- Round robin: req=4'b1111 held for 4 cycles → gnt sequence 0001, 0010, 0100, 1000, then 0001 again. No idle cycles; owner 0,1,2,3,0.
- Lock bound: LOCK_MAX=3; req=4'b0011, lock[0]=1 → gnt[0] held for exactly 3 cycles, then gnt=0010 for 1 cycle, then back to 0001.
- clr_all collision: word 0 = 0x3C; owner 1 commits wdata=0xFF to addr 0 with clr_all=1 in the same cycle → word 0 = 0x00; gnt sequence unchanged.
- Abort and mid-op reset:
  - req[3] dropped during its gnt cycle → no bank change, grant passes on.
  - n_reset=0 while in GRANT with lock → next cycle gnt=0 and all words 0.
